// File: rtl/fighter_pkg.sv
// Shared action codes, screen bounds and sprite geometry for the fighter controllers.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package fighter_pkg;

   localparam int unsigned SPRITE_W    = 128;
   localparam int unsigned SPRITE_H    = 128;
   localparam int unsigned X_LAST      = 783;   // last visible column
   localparam int unsigned GROUND_LINE = 394;   // feet rest on this line

   localparam logic [9:0] X_MIN    = 10'd144;
   localparam logic [9:0] X_MAX    = 10'(X_LAST + 1 - SPRITE_W);
   localparam logic [9:0] GROUND_Y = 10'(GROUND_LINE - SPRITE_H);
   localparam logic [9:0] START_X  = 10'd200;

   // Frame counter must hold the longest action duration minus one.
   localparam int unsigned CNT_W = 5;
   localparam int unsigned DIV_W = 3;

   typedef enum logic [2:0] {
      ACT_IDLE    = 3'd0,
      ACT_WALK    = 3'd1,
      ACT_PUNCH   = 3'd2,
      ACT_KICK    = 3'd3,
      ACT_BLOCK   = 3'd4,
      ACT_HITSTUN = 3'd5
   } action_t;

   // Sub-frame for timed actions: elapsed frames / 4, held at the last frame.
   function automatic logic [1:0] timed_sub_frame(input logic [CNT_W-1:0] cnt);
      logic [1:0] sf;
      if (cnt[CNT_W-1:2] > 3'd3) sf = 2'd3;
      else                       sf = cnt[3:2];
      return sf;
   endfunction

endpackage

// File: rtl/fighter_pos_unit.sv
// Moves a 10-bit sprite x by a step in either direction and clamps it to the playfield.
// Latency: combinational.
// Backpressure: none; result is valid whenever inputs are.
module fighter_pos_unit
   import fighter_pkg::*;
#(
   parameter logic [9:0] LIM_LO = X_MIN,
   parameter logic [9:0] LIM_HI = X_MAX
) (
   input  logic [9:0] pos_cur,
   input  logic       move,
   input  logic       dir_up,
   input  logic [3:0] step,
   output logic [9:0] pos_new
);

   logic [10:0] wide;

   // Widen to 11 bits so neither direction can wrap before the clamp.
   always_comb begin
      wide    = {1'b0, pos_cur};
      pos_new = pos_cur;
      if (move) begin
         if (dir_up)                 wide = {1'b0, pos_cur} + {7'd0, step};
         else if (pos_cur < {6'd0, step}) wide = 11'd0;
         else                        wide = {1'b0, pos_cur} - {7'd0, step};

         if (wide < {1'b0, LIM_LO})      pos_new = LIM_LO;
         else if (wide > {1'b0, LIM_HI}) pos_new = LIM_HI;
         else                            pos_new = wide[9:0];
      end
   end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-player action/position sequencer; all state advances only on frame_tick.
// Latency: outputs update on the clk edge carrying frame_tick and hold until the next one.
// Backpressure: none; hit_in pulses between ticks are latched and applied at the next tick.
module fighter_anim_ctrl
   import fighter_pkg::*;
#(
   parameter logic [9:0]  START_X      = fighter_pkg::START_X,
   parameter logic [9:0]  GROUND_Y     = fighter_pkg::GROUND_Y,
   parameter logic [9:0]  X_MIN        = fighter_pkg::X_MIN,
   parameter logic [9:0]  X_MAX        = fighter_pkg::X_MAX,
   parameter int unsigned WALK_STEP    = 3,
   parameter int unsigned KNOCK_STEP   = 4,
   parameter int unsigned PUNCH_FRAMES = 12,
   parameter int unsigned KICK_FRAMES  = 18,
   parameter int unsigned HIT_FRAMES   = 20,
   parameter int unsigned ATK_START    = 4,
   parameter int unsigned ATK_LEN      = 4,
   parameter int unsigned ANIM_DIV     = 8
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_punch,
   input  logic       btn_kick,
   input  logic       btn_block,
   input  logic       facing_right,
   input  logic       hit_in,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [2:0] action,
   output logic [1:0] anim_frame,
   output logic       attack_active,
   output logic       busy
);

   logic [2:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       anim_q;
   logic             atk_q;
   logic             busy_q;
   logic [9:0]       pos_q;
   logic             hit_pend;

   action_t          cur;
   action_t          nxt;
   logic [CNT_W-1:0] cnt_n;
   logic [CNT_W-1:0] dur_m1;
   logic [DIV_W-1:0] div_n;
   logic [1:0]       anim_n;
   logic             atk_n;
   logic             busy_n;
   logic             hit_now;
   logic             move;
   logic             dir_up;
   logic [3:0]       step;
   logic [9:0]       pos_n;

   fighter_pos_unit #(
      .LIM_LO (X_MIN),
      .LIM_HI (X_MAX)
   ) u_pos (
      .pos_cur (pos_q),
      .move    (move),
      .dir_up  (dir_up),
      .step    (step),
      .pos_new (pos_n)
   );

   // State register and frame-synchronous outputs; hit pulses latch between ticks.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= ACT_IDLE;
         cnt_q    <= '0;
         div_q    <= '0;
         anim_q   <= '0;
         atk_q    <= 1'b0;
         busy_q   <= 1'b0;
         pos_q    <= START_X;
         hit_pend <= 1'b0;
      end else if (frame_tick) begin
         state_q  <= nxt;
         cnt_q    <= cnt_n;
         div_q    <= div_n;
         anim_q   <= anim_n;
         atk_q    <= atk_n;
         busy_q   <= busy_n;
         pos_q    <= pos_n;
         hit_pend <= 1'b0;
      end else if (hit_in) begin
         hit_pend <= 1'b1;
      end
   end

   // Next state, frame counter, motion and animation for the coming frame.
   always_comb begin
      // Codes 6/7 are never written but are treated as IDLE if they appear.
      if (state_q <= 3'd5) cur = action_t'(state_q);
      else                 cur = ACT_IDLE;

      hit_now = hit_pend | hit_in;
      nxt     = cur;
      cnt_n   = cnt_q;
      div_n   = '0;
      anim_n  = 2'd0;

      case (cur)
         ACT_PUNCH: dur_m1 = CNT_W'(PUNCH_FRAMES - 1);
         ACT_KICK:  dur_m1 = CNT_W'(KICK_FRAMES - 1);
         default:   dur_m1 = CNT_W'(HIT_FRAMES - 1);
      endcase

      if (hit_now && cur != ACT_BLOCK) begin
         // A fresh hit always restarts hitstun, even while already stunned.
         nxt   = ACT_HITSTUN;
         cnt_n = '0;
      end else begin
         case (cur)
            ACT_PUNCH, ACT_KICK, ACT_HITSTUN: begin
               if (cnt_q == dur_m1) begin
                  nxt   = ACT_IDLE;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_n = '0;
               if (btn_punch)                  nxt = ACT_PUNCH;
               else if (btn_kick)              nxt = ACT_KICK;
               else if (btn_block)             nxt = ACT_BLOCK;
               else if (btn_left ^ btn_right)  nxt = ACT_WALK;
               else                            nxt = ACT_IDLE;
            end
         endcase
      end

      move   = (nxt == ACT_WALK) || (nxt == ACT_HITSTUN);
      dir_up = (nxt == ACT_WALK) ? btn_right : ~facing_right;
      step   = (nxt == ACT_WALK) ? 4'(WALK_STEP) : 4'(KNOCK_STEP);

      case (nxt)
         ACT_WALK: begin
            // The entering frame counts as the first walk frame of the cycle.
            if (cur == ACT_WALK) begin
               div_n  = (div_q == DIV_W'(ANIM_DIV - 1)) ? '0 : div_q + 1'b1;
               anim_n = (div_n == DIV_W'(ANIM_DIV - 1)) ? anim_q + 2'd1 : anim_q;
            end
         end
         ACT_PUNCH, ACT_KICK, ACT_HITSTUN: anim_n = timed_sub_frame(cnt_n);
         default: anim_n = 2'd0;
      endcase

      atk_n  = ((nxt == ACT_PUNCH) || (nxt == ACT_KICK)) &&
               (32'(cnt_n) >= ATK_START) && (32'(cnt_n) < ATK_START + ATK_LEN);
      busy_n = (nxt == ACT_PUNCH) || (nxt == ACT_KICK) || (nxt == ACT_HITSTUN);
   end

   assign pos_x         = pos_q;
   assign pos_y         = GROUND_Y;
   assign action        = state_q;
   assign anim_frame    = anim_q;
   assign attack_active = atk_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed plus randomized stimulus against a frame-level reference model.
// Latency: outputs checked 1 time unit after each ticked clk edge.
// Backpressure: none.
module tb_fighter_anim_ctrl;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic       frame_tick = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_punch = 1'b0;
   logic       btn_kick = 1'b0, btn_block = 1'b0;
   logic       facing_right = 1'b1;
   logic       hit_in = 1'b0;
   logic [9:0] pos_x, pos_y;
   logic [2:0] action;
   logic [1:0] anim_frame;
   logic       attack_active, busy;

   int total = 0;
   int bad   = 0;

   // Reference model: action code, frames elapsed in the action, walk frames, position.
   int m_act, m_cnt, m_walk, m_x, m_anim;
   bit m_atk, m_busy, m_pend;

   always #5 clk = ~clk;

   fighter_anim_ctrl dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .frame_tick    (frame_tick),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_punch     (btn_punch),
      .btn_kick      (btn_kick),
      .btn_block     (btn_block),
      .facing_right  (facing_right),
      .hit_in        (hit_in),
      .pos_x         (pos_x),
      .pos_y         (pos_y),
      .action        (action),
      .anim_frame    (anim_frame),
      .attack_active (attack_active),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pos_x"},  32'(pos_x),         32'(m_x));
      chk({tag, ".pos_y"},  32'(pos_y),         32'd266);
      chk({tag, ".action"}, 32'(action),        32'(m_act));
      chk({tag, ".anim"},   32'(anim_frame),    32'(m_anim));
      chk({tag, ".atk"},    32'(attack_active), 32'(m_atk));
      chk({tag, ".busy"},   32'(busy),          32'(m_busy));
   endtask

   task automatic model_reset();
      m_act = 0; m_cnt = 0; m_walk = 0; m_x = 200; m_anim = 0;
      m_atk = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
   endtask

   // One frame of the game rules, applied to the model.
   task automatic model_tick(input bit hit_now);
      int nxt;
      int dur;
      bit timed;
      timed = (m_act == 2) || (m_act == 3) || (m_act == 5);
      if (hit_now && m_act != 4) begin
         nxt = 5; m_cnt = 0;
      end else if (timed) begin
         dur = (m_act == 2) ? 12 : (m_act == 3) ? 18 : 20;
         if (m_cnt + 1 == dur) begin nxt = 0; m_cnt = 0; end
         else begin nxt = m_act; m_cnt = m_cnt + 1; end
      end else begin
         m_cnt = 0;
         if (btn_punch)                   nxt = 2;
         else if (btn_kick)               nxt = 3;
         else if (btn_block)              nxt = 4;
         else if (btn_left != btn_right)  nxt = 1;
         else                             nxt = 0;
      end
      if (nxt == 1) m_x = m_x + (btn_right ? 3 : -3);
      if (nxt == 5) m_x = m_x + (facing_right ? -4 : 4);
      if (m_x < 144) m_x = 144;
      if (m_x > 656) m_x = 656;
      m_walk = (nxt == 1) ? ((m_act == 1) ? m_walk + 1 : 1) : 0;
      if (nxt == 1)                           m_anim = (m_walk / 8) % 4;
      else if (nxt == 2 || nxt == 3 || nxt == 5) m_anim = (m_cnt / 4 > 3) ? 3 : m_cnt / 4;
      else                                    m_anim = 0;
      m_atk  = (nxt == 2 || nxt == 3) && m_cnt >= 4 && m_cnt < 8;
      m_busy = (nxt == 2 || nxt == 3 || nxt == 5);
      m_act  = nxt;
   endtask

   task automatic set_btn(input bit l, input bit r, input bit p, input bit k, input bit b);
      btn_left = l; btn_right = r; btn_punch = p; btn_kick = k; btn_block = b;
   endtask

   task automatic tick(input bit hit_with, input string tag);
      @(negedge clk);
      frame_tick = 1'b1;
      hit_in     = hit_with;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      hit_in     = 1'b0;
      model_tick(m_pend | hit_with);
      m_pend = 1'b0;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic hit_mid();
      @(negedge clk);
      hit_in = 1'b1;
      @(negedge clk);
      hit_in = 1'b0;
      m_pend = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_l = 1'b1;
      repeat (3) @(negedge clk);
      check_all("reset_hold");

      // Walk right ten frames: 200 -> 230, sub-frame 1 from the eighth frame on.
      set_btn(0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) tick(1'b0, "walk_r");
      chk("walk_r.x230", 32'(pos_x), 32'd230);

      // No tick: inputs change but outputs must hold.
      set_btn(1, 0, 1, 0, 0);
      repeat (4) @(negedge clk);
      check_all("hold_no_tick");

      // Walk into the right edge and stay clamped.
      set_btn(0, 1, 0, 0, 0);
      for (int i = 0; i < 150; i++) tick(1'b0, "walk_clamp_r");
      chk("clamp_r", 32'(pos_x), 32'd656);
      set_btn(1, 1, 0, 0, 0);
      tick(1'b0, "both_dirs");

      // Punch for one frame, then hold left while it plays out.
      set_btn(0, 0, 1, 0, 0);
      tick(1'b0, "punch_start");
      set_btn(1, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) tick(1'b0, "punch_run");
      set_btn(0, 0, 0, 0, 0);
      tick(1'b0, "punch_end");
      chk("punch_end.idle", 32'(action), 32'd0);

      // Kick, get hit between ticks at frame 5, knocked back left for 20 frames.
      facing_right = 1'b1;
      set_btn(0, 0, 0, 1, 0);
      tick(1'b0, "kick_start");
      set_btn(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick(1'b0, "kick_run");
      hit_mid();
      tick(1'b0, "kick_hit");
      for (int i = 0; i < 20; i++) tick(1'b0, "hitstun");
      chk("hitstun.idle", 32'(action), 32'd0);

      // Blocking absorbs a hit that coincides with the tick; releasing gives IDLE.
      set_btn(0, 0, 0, 0, 1);
      tick(1'b0, "block");
      tick(1'b1, "block_hit");
      set_btn(0, 0, 0, 0, 0);
      tick(1'b0, "block_release");

      // Walk into the left edge.
      set_btn(1, 0, 0, 0, 0);
      for (int i = 0; i < 180; i++) tick(1'b0, "walk_clamp_l");
      chk("clamp_l", 32'(pos_x), 32'd144);

      // Asynchronous reset in the active window of a punch, between clock edges.
      set_btn(0, 0, 1, 0, 0);
      tick(1'b0, "punch2_start");
      set_btn(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick(1'b0, "punch2_run");
      @(negedge clk);
      #2;
      rst_l = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #1;
      rst_l = 1'b1;
      repeat (4) @(negedge clk);
      check_all("post_rst_hold");

      // Randomized play.
      for (int i = 0; i < 400; i++) begin
         set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));
         facing_right = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) hit_mid();
         tick(($urandom_range(0, 11) == 0), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
